// File: rtl/seg_display_mux.sv
// Four-digit multiplexed seven-segment driver for an MM:SS stopwatch readout.
// Scans one digit per REFRESH_DIV cycles, holding a per-frame snapshot of time_.
module seg_display_mux #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] time_,
  input  logic        adj,
  input  logic        sel,
  input  logic        clk_2hz,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    dig_q, dig_d;
  logic [13:0]   snap_q, snap_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          tick;
  logic          blank;

  logic [3:0]    nib [4];
  logic [6:0]    cath [4];

  // Active-low cathode pattern {g,f,e,d,c,b,a}; out-of-range values show a dash.
  function automatic logic [6:0] decode(input logic [3:0] v, input logic is_tens);
    logic [6:0] r;
    r = 7'h3F;
    if (!(is_tens && v >= 4'd6)) begin
      case (v)
        4'd0:    r = 7'h40;
        4'd1:    r = 7'h79;
        4'd2:    r = 7'h24;
        4'd3:    r = 7'h30;
        4'd4:    r = 7'h19;
        4'd5:    r = 7'h12;
        4'd6:    r = 7'h02;
        4'd7:    r = 7'h78;
        4'd8:    r = 7'h00;
        4'd9:    r = 7'h10;
        default: r = 7'h3F;
      endcase
    end
    return r;
  endfunction

  // Digit sources come from snap_d so digit 0 shows the value captured on its own tick.
  assign nib[0] = snap_d[3:0];
  assign nib[1] = {1'b0, snap_d[6:4]};
  assign nib[2] = snap_d[10:7];
  assign nib[3] = {1'b0, snap_d[13:11]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dec
      assign cath[gi] = decode(nib[gi], (gi % 2) == 1);
    end
  endgenerate

  always_comb begin
    tick   = (pcnt_q == PCNT_MAX);
    pcnt_d = tick ? '0 : pcnt_q + PW'(1);
    dig_d  = tick ? dig_q + 2'd1 : dig_q;
    snap_d = (tick && dig_q == 2'd3) ? time_ : snap_q;
    blank  = adj && clk_2hz && (sel ? ~dig_d[1] : dig_d[1]);
    an_d   = an_q;
    seg_d  = seg_q;
    if (tick) begin
      an_d = ~(4'b0001 << dig_d);
      if (blank) begin
        seg_d = 8'hFF;
      end else begin
        seg_d = {(dig_d != 2'd2), cath[dig_d]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pcnt_q <= '0;
      dig_q  <= 2'd3;
      snap_q <= '0;
      an_q   <= 4'hF;
      seg_q  <= 8'hFF;
    end else begin
      pcnt_q <= pcnt_d;
      dig_q  <= dig_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed bench for seg_display_mux: frame order, snapshot coherence, blinking,
// invalid BCD, mid-scan reset and the shortest prescaler.
module tb_seg_display_mux;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] time_;
  logic        adj, sel, clk_2hz;
  logic [3:0]  an, an2;
  logic [7:0]  seg, seg2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seg_display_mux #(.REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset), .time_(time_), .adj(adj), .sel(sel),
    .clk_2hz(clk_2hz), .an(an), .seg(seg)
  );

  seg_display_mux #(.REFRESH_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .time_(time_), .adj(adj), .sel(sel),
    .clk_2hz(clk_2hz), .an(an2), .seg(seg2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [13:0] bcd(input int mt, input int mo, input int st, input int so);
    logic [2:0] a;
    logic [3:0] b;
    logic [2:0] c;
    logic [3:0] d;
    a = mt[2:0];
    b = mo[3:0];
    c = st[2:0];
    d = so[3:0];
    return {a, b, c, d};
  endfunction

  // One digit slot is 4 cycles; check every cycle of it.
  task automatic expect_slot(input string tag, input logic [3:0] an_e, input logic [7:0] seg_e);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check({tag, "_an"}, 32'(an), 32'(an_e));
      check({tag, "_seg"}, 32'(seg), 32'(seg_e));
    end
    $display("slot %s an=%h seg=%h", tag, an, seg);
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
    expect_slot({tag, "_d0"}, 4'hE, s0);
    expect_slot({tag, "_d1"}, 4'hD, s1);
    expect_slot({tag, "_d2"}, 4'hB, s2);
    expect_slot({tag, "_d3"}, 4'h7, s3);
  endtask

  task automatic await_first_tick(input string tag);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check({tag, "_pre_an"}, 32'(an), 32'hF);
      check({tag, "_pre_seg"}, 32'(seg), 32'hFF);
    end
  endtask

  initial begin
    logic [3:0] e;
    reset   = 1'b0;
    time_   = bcd(1, 2, 3, 4);
    adj     = 1'b0;
    sel     = 1'b0;
    clk_2hz = 1'b0;

    // Reset and first frame of 12:34
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_an2", 32'(an2), 32'hF);
    reset = 1'b1;
    await_first_tick("first");
    expect_frame("f1", 8'h99, 8'hB0, 8'h24, 8'hF9);

    // Snapshot coherence: 09:59 -> 10:00 while digit 1 is shown
    time_ = bcd(0, 9, 5, 9);
    expect_slot("coh_d0", 4'hE, 8'h90);
    expect_slot("coh_d1", 4'hD, 8'h92);
    time_ = bcd(1, 0, 0, 0);
    expect_slot("coh_d2", 4'hB, 8'h10);
    expect_slot("coh_d3", 4'h7, 8'hC0);
    expect_frame("new", 8'hC0, 8'hC0, 8'h40, 8'hF9);

    // Blinking
    time_ = bcd(1, 2, 3, 4);
    adj = 1'b1; sel = 1'b1; clk_2hz = 1'b1;
    expect_frame("blk_sec", 8'hFF, 8'hFF, 8'h24, 8'hF9);
    sel = 1'b0;
    expect_frame("blk_min", 8'h99, 8'hB0, 8'hFF, 8'hFF);
    clk_2hz = 1'b0;
    expect_frame("blk_low", 8'h99, 8'hB0, 8'h24, 8'hF9);
    adj = 1'b0; clk_2hz = 1'b1;
    expect_frame("noadj", 8'h99, 8'hB0, 8'h24, 8'hF9);
    clk_2hz = 1'b0;

    // Invalid BCD in every position
    time_ = bcd(7, 10, 6, 12);
    expect_frame("bad", 8'hBF, 8'hBF, 8'h3F, 8'hBF);

    // Reset during digit 2
    time_ = bcd(1, 2, 3, 4);
    expect_slot("mid_d0", 4'hE, 8'h99);
    expect_slot("mid_d1", 4'hD, 8'hB0);
    @(negedge clk);
    check("mid_d2_an", 32'(an), 32'hB);
    check("mid_d2_seg", 32'(seg), 32'h24);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_an", 32'(an), 32'hF);
    check("mid_rst_seg", 32'(seg), 32'hFF);
    reset = 1'b1;
    await_first_tick("restart");
    expect_slot("rs_d0", 4'hE, 8'h99);
    expect_slot("rs_d1", 4'hD, 8'hB0);

    // Shortest prescaler: one-hot scan every 2 cycles
    reset = 1'b0;
    @(negedge clk);
    check("p2_rst_an", 32'(an2), 32'hF);
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k < 2) begin
        e = 4'hF;
      end else begin
        case (((k - 2) / 2) % 4)
          0:       e = 4'hE;
          1:       e = 4'hD;
          2:       e = 4'hB;
          default: e = 4'h7;
        endcase
        check("p2_onehot", 32'($countones(~an2)), 32'd1);
      end
      check("p2_an", 32'(an2), 32'(e));
    end
    $display("prescaler-2 scan done an2=%h", an2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
